// File: rtl/neuron_out_requant_if.sv
// Handshake bundle between the neuron requant FIFO and its producer/consumer.
// The slave side is the FIFO; the master side is the neuron plus next-layer loader.
interface neuron_out_requant_if #(
  parameter int DEPTH   = 4,
  parameter int SHIFT_W = 4
);
  logic                       in_valid;
  logic [17:0]                in_y;
  logic [SHIFT_W-1:0]         shift;
  logic                       in_ready;
  logic                       out_valid;
  logic [7:0]                 out_data;
  logic                       out_ready;
  logic [$clog2(DEPTH):0]     count;
  logic                       overflow;
  logic                       clr_err;

  modport slave (
    input  in_valid, in_y, shift, out_ready, clr_err,
    output in_ready, out_valid, out_data, count, overflow
  );

  modport master (
    output in_valid, in_y, shift, out_ready, clr_err,
    input  in_ready, out_valid, out_data, count, overflow
  );
endinterface

// File: rtl/neuron_out_requant.sv
// Requantizes 18-bit ReLU outputs to int8 (rounding shift + saturation) and
// buffers them in a small drop-on-full FIFO drained over valid/ready.
module neuron_out_requant #(
  parameter int DEPTH   = 4,
  parameter int SHIFT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  neuron_out_requant_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic [18:0]   w_rnd;
  logic [18:0]   w_sum;
  logic [18:0]   w_shr;
  logic [7:0]    w_q;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;

  // Non-negative input is at most 17 bits, so the rounded sum never overflows 19 bits.
  always_comb begin
    w_rnd = '0;
    if (bus.shift != '0)
      w_rnd = 19'(1) << (bus.shift - SHIFT_W'(1));
    w_sum = {2'b00, bus.in_y[16:0]} + w_rnd;
    w_shr = w_sum >> bus.shift;
    if (bus.in_y[17])
      w_q = 8'd0;
    else if (w_shr > 19'd127)
      w_q = 8'd127;
    else
      w_q = {1'b0, w_shr[6:0]};
  end

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.in_valid & ~w_full;
  assign w_pop   = bus.out_ready & ~w_empty;
  assign w_drop  = bus.in_valid & w_full;

  // Storage carries no reset so it can map onto plain memory.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wptr] <= w_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + PW'(1);
      if (w_pop)
        r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A drop on the same edge as a clear leaves the flag set.
      if (w_drop)
        r_overflow <= 1'b1;
      else if (bus.clr_err)
        r_overflow <= 1'b0;
    end
  end

  assign bus.in_ready  = ~w_full;
  assign bus.out_valid = ~w_empty;
  assign bus.out_data  = w_empty ? 8'd0 : r_mem[r_rptr];
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;
endmodule
